// File: rtl/mem_arb_pkg.sv
// Shared defaults and slice helpers for the
// shared DataMemory port arbiter.
package mem_arb_pkg;

  localparam int NUM_CORES = 4;
  localparam int ADDR_W    = 32;
  localparam int DATA_W    = 32;
  localparam int GID_W     = $clog2(NUM_CORES);

  // Low bit of core i's field in a flattened address bus
  function automatic int slice_addr(
    input int i,
    input int w = ADDR_W
  );
    return i * w;
  endfunction

  // Low bit of core i's field in a flattened data bus
  function automatic int slice_data(
    input int i,
    input int w = DATA_W
  );
    return i * w;
  endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker: first set
// request at or after the pointer, wrapping.
module rr_priority_picker #(
  parameter int N  = 4,
  parameter int GW = $clog2(N)
) (
  input  logic [N-1:0]  i_req,
  input  logic [GW-1:0] i_ptr,
  output logic          o_grant_valid,
  output logic [GW-1:0] o_grant_id
);

  // Scan from farthest to nearest so the nearest wins
  always_comb begin
    int w_idx;
    w_idx         = 0;
    o_grant_valid = 1'b0;
    o_grant_id    = '0;
    for (int k = N - 1; k >= 0; k--) begin
      w_idx = (int'(i_ptr) + k) % N;
      if (i_req[w_idx]) begin
        o_grant_valid = 1'b1;
        o_grant_id    = GW'(w_idx);
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin sharing of one DataMemory port
// among several core MEM stages.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NUM_CORES = mem_arb_pkg::NUM_CORES,
  parameter int ADDR_W    = mem_arb_pkg::ADDR_W,
  parameter int DATA_W    = mem_arb_pkg::DATA_W
) (
  input  logic                        Clk,
  input  logic                        Rst,
  input  logic [NUM_CORES-1:0]        Core_Req,
  input  logic [NUM_CORES-1:0]        Core_MemRead,
  input  logic [NUM_CORES-1:0]        Core_MemWrite,
  input  logic [NUM_CORES-1:0]        Core_Half,
  input  logic [NUM_CORES-1:0]        Core_Byte,
  input  logic [NUM_CORES*ADDR_W-1:0] Core_Address,
  input  logic [NUM_CORES*DATA_W-1:0] Core_WriteData,
  output logic [NUM_CORES*DATA_W-1:0] Core_ReadData,
  output logic [NUM_CORES-1:0]        Core_Ack,
  output logic [NUM_CORES-1:0]        Core_Stall,
  output logic [ADDR_W-1:0]           Mem_Address,
  output logic [DATA_W-1:0]           Mem_WriteData,
  output logic                        Mem_MemRead,
  output logic                        Mem_MemWrite,
  output logic                        Mem_Half,
  output logic                        Mem_Byte,
  input  logic [DATA_W-1:0]           Mem_ReadData,
  output logic                        Grant_Valid,
  output logic [$clog2(NUM_CORES)-1:0] Grant_Id
);

  localparam int GW = $clog2(NUM_CORES);

  logic [GW-1:0]               r_ptr;
  logic [NUM_CORES-1:0]        r_ack;
  logic [NUM_CORES*DATA_W-1:0] r_rdata;
  logic [NUM_CORES-1:0]        w_elig;
  logic                        w_gv;
  logic [GW-1:0]               w_gid;

  // A core in its Ack cycle is masked so a held
  // Req is not served twice; reset blocks grants.
  assign w_elig = Core_Req
                & (Core_MemRead | Core_MemWrite)
                & ~r_ack
                & {NUM_CORES{~Rst}};

  rr_priority_picker #(
    .N  (NUM_CORES),
    .GW (GW)
  ) u_pick (
    .i_req         (w_elig),
    .i_ptr         (r_ptr),
    .o_grant_valid (w_gv),
    .o_grant_id    (w_gid)
  );

  assign Grant_Valid   = w_gv;
  assign Grant_Id      = w_gid;
  assign Core_Ack      = r_ack;
  assign Core_ReadData = r_rdata;
  assign Core_Stall    = Core_Req & ~r_ack;

  // Route the granted core's op to the memory port
  always_comb begin
    Mem_Address   = '0;
    Mem_WriteData = '0;
    Mem_MemRead   = 1'b0;
    Mem_MemWrite  = 1'b0;
    Mem_Half      = 1'b0;
    Mem_Byte      = 1'b0;
    for (int i = 0; i < NUM_CORES; i++) begin
      if (w_gv && w_gid == GW'(i)) begin
        Mem_Address   = Core_Address[slice_addr(i, ADDR_W) +: ADDR_W];
        Mem_WriteData = Core_WriteData[slice_data(i, DATA_W) +: DATA_W];
        Mem_MemRead   = Core_MemRead[i];
        Mem_MemWrite  = Core_MemWrite[i];
        Mem_Half      = Core_Half[i];
        Mem_Byte      = Core_Byte[i];
      end
    end
  end

  // Capture read data, pulse Ack, advance pointer
  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_ptr   <= '0;
      r_ack   <= '0;
      r_rdata <= '0;
    end else begin
      r_ack <= '0;
      if (w_gv) begin
        r_ptr <= (w_gid == GW'(NUM_CORES - 1)) ? '0 : w_gid + 1'b1;
      end
      for (int i = 0; i < NUM_CORES; i++) begin
        if (w_gv && w_gid == GW'(i)) begin
          r_ack[i] <= 1'b1;
          r_rdata[slice_data(i, DATA_W) +: DATA_W] <= Mem_ReadData;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a
// word-addressed memory model on the shared port.
module tb_mem_port_arbiter;

  logic         Clk;
  logic         Rst;
  logic [3:0]   Core_Req;
  logic [3:0]   Core_MemRead;
  logic [3:0]   Core_MemWrite;
  logic [3:0]   Core_Half;
  logic [3:0]   Core_Byte;
  logic [127:0] Core_Address;
  logic [127:0] Core_WriteData;
  logic [127:0] Core_ReadData;
  logic [3:0]   Core_Ack;
  logic [3:0]   Core_Stall;
  logic [31:0]  Mem_Address;
  logic [31:0]  Mem_WriteData;
  logic         Mem_MemRead;
  logic         Mem_MemWrite;
  logic         Mem_Half;
  logic         Mem_Byte;
  logic [31:0]  Mem_ReadData;
  logic         Grant_Valid;
  logic [1:0]   Grant_Id;

  logic [31:0] mem  [0:63];
  int          wcnt [0:63];
  int          n_chk;
  int          n_err;

  mem_port_arbiter dut (
    .Clk            (Clk),
    .Rst            (Rst),
    .Core_Req       (Core_Req),
    .Core_MemRead   (Core_MemRead),
    .Core_MemWrite  (Core_MemWrite),
    .Core_Half      (Core_Half),
    .Core_Byte      (Core_Byte),
    .Core_Address   (Core_Address),
    .Core_WriteData (Core_WriteData),
    .Core_ReadData  (Core_ReadData),
    .Core_Ack       (Core_Ack),
    .Core_Stall     (Core_Stall),
    .Mem_Address    (Mem_Address),
    .Mem_WriteData  (Mem_WriteData),
    .Mem_MemRead    (Mem_MemRead),
    .Mem_MemWrite   (Mem_MemWrite),
    .Mem_Half       (Mem_Half),
    .Mem_Byte       (Mem_Byte),
    .Mem_ReadData   (Mem_ReadData),
    .Grant_Valid    (Grant_Valid),
    .Grant_Id       (Grant_Id)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  assign Mem_ReadData = mem[Mem_Address[7:2]];

  always @(posedge Clk) begin
    if (Mem_MemWrite) begin
      mem[Mem_Address[7:2]]  <= Mem_WriteData;
      wcnt[Mem_Address[7:2]] <= wcnt[Mem_Address[7:2]] + 1;
    end
  end

  task automatic check(
    input string       tag,
    input logic [63:0] got,
    input logic [63:0] exp
  );
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic op(
    input int          c,
    input logic        rd,
    input logic        wr,
    input logic [31:0] a,
    input logic [31:0] d
  );
    Core_Req[c]                = 1'b1;
    Core_MemRead[c]            = rd;
    Core_MemWrite[c]           = wr;
    Core_Address[c*32 +: 32]   = a;
    Core_WriteData[c*32 +: 32] = d;
  endtask

  task automatic drop(input int c);
    Core_Req[c]      = 1'b0;
    Core_MemRead[c]  = 1'b0;
    Core_MemWrite[c] = 1'b0;
  endtask

  function automatic logic [31:0] rdat(input int c);
    return Core_ReadData[c*32 +: 32];
  endfunction

  initial begin
    n_chk = 0;
    n_err = 0;
    for (int i = 0; i < 64; i++) begin
      mem[i]  = 32'h0;
      wcnt[i] = 0;
    end
    mem[4]  = 32'hDEADBEEF;
    mem[5]  = 32'h1111_0001;
    mem[9]  = 32'h0000_2424;
    mem[12] = 32'h3333_0003;
    mem[13] = 32'h3434_0004;
    Rst            = 1'b1;
    Core_Req       = '0;
    Core_MemRead   = '0;
    Core_MemWrite  = '0;
    Core_Half      = '0;
    Core_Byte      = '0;
    Core_Address   = '0;
    Core_WriteData = '0;

    // Reset with every core requesting a store
    @(negedge Clk);
    for (int c = 0; c < 4; c++)
      op(c, 1'b0, 1'b1, 32'h40 + 32'(4 * c), 32'hA0 + 32'(c));
    #1;
    check("rst_memwrite", 64'(Mem_MemWrite), 64'd0);
    check("rst_gv", 64'(Grant_Valid), 64'd0);
    check("rst_stall", 64'(Core_Stall), 64'hF);
    @(negedge Clk);
    #1;
    check("rst_ack", 64'(Core_Ack), 64'd0);
    check("rst_rdata", Core_ReadData[63:0], 64'd0);
    check("rst_nowrite", 64'(wcnt[16] + wcnt[17]), 64'd0);

    // Contention: grants 0..3 on cycles 0..3
    for (int cyc = 0; cyc < 6; cyc++) begin
      @(negedge Clk);
      if (cyc == 0) Rst = 1'b0;
      if (cyc >= 2) drop(cyc - 2);
      #1;
      check($sformatf("cont_ack%0d", cyc), 64'(Core_Ack),
            (cyc >= 1 && cyc <= 4) ? 64'(4'b1 << (cyc - 1)) : 64'd0);
      check($sformatf("cont_gv%0d", cyc), 64'(Grant_Valid),
            64'(cyc <= 3));
      check($sformatf("cont_gid%0d", cyc), 64'(Grant_Id),
            (cyc <= 3) ? 64'(cyc) : 64'd0);
    end
    for (int c = 0; c < 4; c++) begin
      check($sformatf("cont_mem%0d", c), 64'(mem[16 + c]),
            64'hA0 + 64'(c));
      check($sformatf("cont_wcnt%0d", c), 64'(wcnt[16 + c]), 64'd1);
    end

    // Lone load from core 2
    @(negedge Clk);
    op(2, 1'b1, 1'b0, 32'h10, 32'h0);
    #1;
    check("load_gv", 64'(Grant_Valid), 64'd1);
    check("load_gid", 64'(Grant_Id), 64'd2);
    check("load_stall_t", 64'(Core_Stall[2]), 64'd1);
    check("load_maddr", 64'(Mem_Address), 64'h10);
    check("load_mrd", 64'(Mem_MemRead), 64'd1);
    @(negedge Clk);
    #1;
    check("load_ack", 64'(Core_Ack), 64'b0100);
    check("load_rdata", 64'(rdat(2)), 64'hDEADBEEF);
    check("load_stall_t1", 64'(Core_Stall[2]), 64'd0);
    check("load_gv_t1", 64'(Grant_Valid), 64'd0);
    @(negedge Clk);
    drop(2);
    #1;
    check("load_ack_t2", 64'(Core_Ack), 64'd0);

    // Wrap: pointer at 3, cores 0 and 3 request
    @(negedge Clk);
    op(0, 1'b1, 1'b0, 32'h30, 32'h0);
    op(3, 1'b1, 1'b0, 32'h34, 32'h0);
    #1;
    check("wrap_gid3", 64'(Grant_Id), 64'd3);
    @(negedge Clk);
    #1;
    check("wrap_ack3", 64'(Core_Ack), 64'b1000);
    check("wrap_gid0", 64'(Grant_Id), 64'd0);
    check("wrap_gv0", 64'(Grant_Valid), 64'd1);
    check("wrap_rd3", 64'(rdat(3)), 64'h3434_0004);
    @(negedge Clk);
    drop(3);
    #1;
    check("wrap_ack0", 64'(Core_Ack), 64'b0001);
    check("wrap_idle", 64'(Grant_Valid), 64'd0);
    check("wrap_rd0", 64'(rdat(0)), 64'h3333_0003);
    @(negedge Clk);
    drop(0);
    op(1, 1'b1, 1'b0, 32'h14, 32'h0);
    #1;
    check("wrap_gid1", 64'(Grant_Id), 64'd1);
    check("wrap_gv1", 64'(Grant_Valid), 64'd1);
    @(negedge Clk);
    #1;
    check("wrap_ack1", 64'(Core_Ack), 64'b0010);
    check("wrap_rd1", 64'(rdat(1)), 64'h1111_0001);

    // Store then load on core 0, pointer at 2
    @(negedge Clk);
    drop(1);
    op(0, 1'b0, 1'b1, 32'h20, 32'h55);
    #1;
    check("sl_st_gid", 64'(Grant_Id), 64'd0);
    check("sl_st_gv", 64'(Grant_Valid), 64'd1);
    check("sl_st_mwr", 64'(Mem_MemWrite), 64'd1);
    @(negedge Clk);
    #1;
    check("sl_st_ack", 64'(Core_Ack), 64'b0001);
    check("sl_nogrant_t1", 64'(Grant_Valid), 64'd0);
    @(negedge Clk);
    op(0, 1'b1, 1'b0, 32'h20, 32'h0);
    #1;
    check("sl_ld_gid", 64'(Grant_Id), 64'd0);
    check("sl_ld_gv", 64'(Grant_Valid), 64'd1);
    @(negedge Clk);
    #1;
    check("sl_ld_ack", 64'(Core_Ack), 64'b0001);
    check("sl_ld_rdata", 64'(rdat(0)), 64'h55);
    check("sl_mem", 64'(mem[8]), 64'h55);

    // Req without Read or Write is never granted
    @(negedge Clk);
    drop(0);
    Core_Req[2] = 1'b1;
    #1;
    check("nop_gv", 64'(Grant_Valid), 64'd0);
    check("nop_stall", 64'(Core_Stall), 64'b0100);
    @(negedge Clk);
    #1;
    check("nop_ack", 64'(Core_Ack), 64'd0);

    // Reset during core 1's store grant
    @(negedge Clk);
    drop(2);
    op(1, 1'b0, 1'b1, 32'h24, 32'h77);
    #1;
    check("rmid_gid", 64'(Grant_Id), 64'd1);
    check("rmid_gv", 64'(Grant_Valid), 64'd1);
    Rst = 1'b1;
    #1;
    check("rmid_gv_rst", 64'(Grant_Valid), 64'd0);
    check("rmid_mwr_rst", 64'(Mem_MemWrite), 64'd0);
    @(negedge Clk);
    Rst = 1'b0;
    drop(1);
    #1;
    check("rmid_ack", 64'(Core_Ack), 64'd0);
    check("rmid_mem", 64'(mem[9]), 64'h2424);
    check("rmid_wcnt", 64'(wcnt[9]), 64'd0);
    check("rmid_rd0", 64'(rdat(0)), 64'd0);

    // Pointer back at 0 after reset
    @(negedge Clk);
    op(0, 1'b1, 1'b0, 32'h30, 32'h0);
    op(3, 1'b1, 1'b0, 32'h34, 32'h0);
    #1;
    check("pr_gid0", 64'(Grant_Id), 64'd0);
    @(negedge Clk);
    #1;
    check("pr_ack0", 64'(Core_Ack), 64'b0001);
    check("pr_gid3", 64'(Grant_Id), 64'd3);
    @(negedge Clk);
    drop(0);
    #1;
    check("pr_ack3", 64'(Core_Ack), 64'b1000);
    @(negedge Clk);
    drop(3);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_err);
    $finish;
  end

endmodule
